// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the instruction fetch path: widths, reset address
// and fetch FSM state encodings.
package fetch_unit_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
endpackage

// File: rtl/fetch_unit_pc_adder.sv
// Modulo-256 address incrementer: adds 1 or 2 to a byte address.
module pc_adder
    import fetch_unit_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic              step2,
    output logic [ADDR_W-1:0] sum
);
    // Increment is 2'b10 or 2'b01; the carry out of bit 7 drops, giving the wrap.
    assign sum = addr + {{(ADDR_W-2){1'b0}}, step2, ~step2};
endmodule

// File: rtl/fetch_unit.sv
// Two-byte instruction fetcher: reads high then low byte over a byte-wide
// memory port, presents the word to decode and holds it until accepted.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  next_pc,
    input  logic               pc_load,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_req,
    input  logic [7:0]         mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    input  logic               instr_ready
);
    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] addr_p1;
    logic [ADDR_W-1:0] addr_p2;

    pc_adder u_inc1 (.addr(fetch_pc), .step2(1'b0), .sum(addr_p1));
    pc_adder u_inc2 (.addr(fetch_pc), .step2(1'b1), .sum(addr_p2));

    // Request lines depend only on registered state, so the address is stable
    // for the whole cycle while the memory is stalling.
    always_comb begin
        mem_req  = (state == S_HI) || (state == S_LO);
        mem_addr = (state == S_LO) ? addr_p1 : fetch_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            hi_byte     <= 8'h00;
            instr       <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
        end else if (pc_load) begin
            // Redirect wins over any completing access or handshake; a partial
            // or just-finished word is simply never presented.
            state       <= S_HI;
            fetch_pc    <= next_pc;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_HI;
                S_HI: begin
                    if (mem_ack) begin
                        hi_byte <= mem_rdata;
                        state   <= S_LO;
                    end
                end
                S_LO: begin
                    if (mem_ack) begin
                        instr       <= {hi_byte, mem_rdata};
                        pc          <= fetch_pc;
                        fetch_pc    <= addr_p2;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_HI;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream model driven by a wait-state memory responder.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  next_pc = 8'h00;
    logic        pc_load = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    int   wait_n = 0;
    bit   junk = 1'b0;
    int   cnt = 0;
    logic [7:0] last_addr = 8'h00;
    logic last_req = 1'b0;
    logic last_ack = 1'b0;

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .pc_load(pc_load),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .instr(instr), .pc(pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Memory responder: acks an access after wait_n stalled cycles at one address;
    // optionally throws spurious acks while no request is active.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (mem_req) begin
            if (last_req && !last_ack && mem_addr == last_addr) cnt++;
            else cnt = 0;
            mem_ack   = (cnt >= wait_n);
            mem_rdata = mem_ack ? mem[mem_addr] : 8'($urandom);
        end else begin
            mem_ack   = junk && ($urandom_range(0, 1) == 1);
            mem_rdata = 8'($urandom);
        end
        last_req  = mem_req;
        last_ack  = mem_ack;
        last_addr = mem_addr;
    end

    task automatic do_reset();
        rst = 1'b1; pc_load = 1'b0; next_pc = 8'h00; instr_ready = 1'b0;
        wait_n = 0; junk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", mem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instr); end
        n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", pc); end
    endtask

    task automatic test_first_fetch();
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        do_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL ff_c1 got req=%b addr=%h v=%b want 1/00/0", mem_req, mem_addr, instr_valid); end
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h01, 1'b0}) begin n_fail++; $display("FAIL ff_c2 got req=%b addr=%h v=%b want 1/01/0", mem_req, mem_addr, instr_valid); end
        @(negedge clk);
        n_cmp++; if ({instr_valid, instr, pc, mem_req} !== {1'b1, 16'h1234, 8'h00, 1'b0}) begin n_fail++; $display("FAIL ff_c3 got v=%b instr=%h pc=%h req=%b want 1/1234/00/0", instr_valid, instr, pc, mem_req); end
        @(negedge clk);
        n_cmp++; if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h02}) begin n_fail++; $display("FAIL ff_c4 got v=%b req=%b addr=%h want 0/1/02", instr_valid, mem_req, mem_addr); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({instr_valid, instr, pc} !== {1'b1, 16'h5678, 8'h02}) begin n_fail++; $display("FAIL ff_thru got v=%b instr=%h pc=%h want 1/5678/02", instr_valid, instr, pc); end
    endtask

    task automatic test_wait_states();
        bit ok;
        do_reset();
        wait_n = 3; instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL ws_hold%0d got req=%b addr=%h want 1/00", k, mem_req, mem_addr); end
        end
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL ws_lo got req=%b addr=%h want 1/01", mem_req, mem_addr); end
        wait_valid(20, ok);
        n_cmp++; if ({ok, instr, pc} !== {1'b1, 16'h1234, 8'h00}) begin n_fail++; $display("FAIL ws_instr got ok=%b instr=%h pc=%h want 1/1234/00", ok, instr, pc); end
        wait_n = 0;
    endtask

    task automatic test_hold_stall();
        bit ok;
        do_reset();
        junk = 1'b1;
        wait_valid(10, ok);
        n_cmp++; if ({ok, instr, pc} !== {1'b1, 16'h1234, 8'h00}) begin n_fail++; $display("FAIL hs_first got ok=%b instr=%h pc=%h want 1/1234/00", ok, instr, pc); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if ({instr_valid, mem_req, instr, pc} !== {1'b1, 1'b0, 16'h1234, 8'h00}) begin n_fail++; $display("FAIL hs_stall%0d got v=%b req=%b instr=%h pc=%h want 1/0/1234/00", k, instr_valid, mem_req, instr, pc); end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h02}) begin n_fail++; $display("FAIL hs_release got v=%b req=%b addr=%h want 0/1/02", instr_valid, mem_req, mem_addr); end
        junk = 1'b0;
    endtask

    task automatic test_load_in_lo();
        bit ok;
        do_reset();
        instr_ready = 1'b1;
        mem[8'h40] = 8'h9A; mem[8'h41] = 8'hBC;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL ld_inlo got req=%b addr=%h want 1/01", mem_req, mem_addr); end
        pc_load = 1'b1; next_pc = 8'h40;
        @(negedge clk);
        pc_load = 1'b0;
        n_cmp++; if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h40}) begin n_fail++; $display("FAIL ld_drop got v=%b req=%b addr=%h want 0/1/40", instr_valid, mem_req, mem_addr); end
        wait_valid(10, ok);
        n_cmp++; if ({ok, instr, pc} !== {1'b1, 16'h9ABC, 8'h40}) begin n_fail++; $display("FAIL ld_first got ok=%b instr=%h pc=%h want 1/9abc/40", ok, instr, pc); end
    endtask

    task automatic test_load_in_hold();
        bit ok;
        do_reset();
        mem[8'h80] = 8'h5A; mem[8'h81] = 8'hA5;
        wait_valid(10, ok);
        n_cmp++; if ({ok, pc} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL lh_held got ok=%b pc=%h want 1/00", ok, pc); end
        instr_ready = 1'b1; pc_load = 1'b1; next_pc = 8'h80;
        @(negedge clk);
        pc_load = 1'b0;
        n_cmp++; if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h80}) begin n_fail++; $display("FAIL lh_redirect got v=%b req=%b addr=%h want 0/1/80", instr_valid, mem_req, mem_addr); end
        wait_valid(10, ok);
        n_cmp++; if ({ok, instr, pc} !== {1'b1, 16'h5AA5, 8'h80}) begin n_fail++; $display("FAIL lh_next got ok=%b instr=%h pc=%h want 1/5aa5/80", ok, instr, pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        mem[8'hFF] = 8'hAB; mem[8'h00] = 8'hCD;
        @(negedge clk);
        pc_load = 1'b1; next_pc = 8'hFF;
        @(negedge clk);
        pc_load = 1'b0;
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL wr_hi got req=%b addr=%h want 1/ff", mem_req, mem_addr); end
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL wr_lo got req=%b addr=%h want 1/00", mem_req, mem_addr); end
        @(negedge clk);
        n_cmp++; if ({instr_valid, instr, pc} !== {1'b1, 16'hABCD, 8'hFF}) begin n_fail++; $display("FAIL wr_instr got v=%b instr=%h pc=%h want 1/abcd/ff", instr_valid, instr, pc); end
        instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL wr_next got req=%b addr=%h want 1/01", mem_req, mem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h03}) begin n_fail++; $display("FAIL rm_inlo got req=%b addr=%h want 1/03", mem_req, mem_addr); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({instr_valid, mem_req, mem_addr, instr} !== {1'b0, 1'b0, 8'h00, 16'h0000}) begin n_fail++; $display("FAIL rm_abort got v=%b req=%b addr=%h instr=%h want 0/0/00/0000", instr_valid, mem_req, mem_addr, instr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL rm_refetch got req=%b addr=%h want 1/00", mem_req, mem_addr); end
    endtask

    // Model: the presented word must be the two bytes at the expected PC; the
    // expected PC advances by 2 on every acceptance and jumps on every redirect.
    task automatic test_random();
        logic [7:0] exp_pc, e1, prev_addr;
        logic prev_req, prev_ack, prev_load;
        int idle, accepted;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        junk = 1'b1;
        exp_pc = 8'h00; idle = 0; accepted = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_load = 1'b0; prev_addr = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (instr_valid === 1'b1) begin
                e1 = exp_pc + 8'd1;
                n_cmp++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h want %h", c, pc, exp_pc); end
                n_cmp++; if (instr !== {mem[exp_pc], mem[e1]}) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %h want %h", c, instr, {mem[exp_pc], mem[e1]}); end
                idle = 0;
            end else if (++idle > 200) begin
                n_cmp++; n_fail++; $display("FAIL rnd_stall cyc %0d got no valid in 200 cycles want progress", c);
                idle = 0;
            end
            if (prev_req && !prev_ack && !prev_load && mem_req) begin
                n_cmp++; if (mem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_addr_stable cyc %0d got %h want %h", c, mem_addr, prev_addr); end
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
            instr_ready = ($urandom_range(0, 1) == 1);
            wait_n = $urandom_range(0, 2);
            pc_load = ($urandom_range(0, 15) == 0);
            next_pc = 8'($urandom);
            prev_load = pc_load;
            if (pc_load) exp_pc = next_pc;
            else if (instr_valid && instr_ready) begin exp_pc = exp_pc + 8'd2; accepted++; end
        end
        pc_load = 1'b0; junk = 1'b0;
        n_cmp++; if (accepted < 50) begin n_fail++; $display("FAIL rnd_accepted got %0d want >= 50", accepted); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_hold_stall();
        test_load_in_lo();
        test_load_in_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no completion want finish within bound");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: fetch address used after reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 next_pc  input  8  next-PC value from the 2:1 8-bit next-PC select mux (branch target or sequential).
REQ-005 pc_load  input  1  when high, load next_pc as fetch address and flush (taken branch/jump).
REQ-006 mem_addr  output  8  instruction-memory byte address.
REQ-007 mem_req  output  1  memory read request.
REQ-008 mem_rdata  input  8  memory read data, valid when mem_ack high.
REQ-009 mem_ack  input  1  memory read complete; may be high in the same cycle as mem_req.
REQ-010 instr  output  16  fetched instruction, {high byte, low byte}.
REQ-011 pc  output  8  address of the first byte of instr.
REQ-012 instr_valid  output  1  instr and pc are valid.
REQ-013 instr_ready  input  1  decode accepts instr this cycle.

Function
REQ-014 FSM states: S_IDLE, S_HI, S_LO and S_HOLD; S_IDLE transitions to S_HI unconditionally on the next clock edge.
REQ-015 S_HI: mem_req=1, mem_addr=fetch_pc; on mem_ack, capture mem_rdata as the high byte and go to S_LO; otherwise stay in S_HI.
REQ-016 S_LO: mem_req=1, mem_addr=fetch_pc+1 mod 256; on mem_ack, register instr={hi,mem_rdata}, pc=fetch_pc and fetch_pc=fetch_pc+2 mod 256, set instr_valid=1 and go to S_HOLD.
REQ-017 S_HOLD: mem_req=0, instr_valid=1; on instr_ready go to S_HI with instr_valid=0 from the next cycle; otherwise hold instr and pc stable.
REQ-018 mem_req=0 in S_IDLE and S_HOLD; mem_addr and mem_req are decoded combinationally from the registered state and fetch_pc.
REQ-019 Latency with zero-wait memory: instr_valid rises 2 cycles after entry to S_HI; throughput is one instruction per 3 cycles when instr_ready is held high.
REQ-020 While mem_req=1 and mem_ack=0, mem_addr stays constant except on pc_load.
REQ-021 mem_ack while mem_req=0 is ignored.
REQ-022 pc_load (any state except reset): fetch_pc<=next_pc, the partial high byte is discarded, instr_valid<=0 and state<=S_HI; pc_load takes precedence over mem_ack and instr_ready.
REQ-023 pc_load together with mem_ack in S_LO: the completed word is discarded and is not presented.
REQ-024 pc_load together with instr_ready in S_HOLD: the held instruction counts as consumed, with no duplicate and no loss.
REQ-025 Address wrap: fetch_pc=8'hFF fetches bytes FF then 00, and the next fetch_pc is 8'h01.
REQ-026 instr and pc change only on the S_LO-to-S_HOLD transition.

Reset
REQ-027 rst high asynchronously forces state=S_IDLE, fetch_pc=RESET_PC, instr=16'h0000, pc=8'h00 and instr_valid=0, giving mem_req=0 and mem_addr=RESET_PC.
REQ-028 Reset asserted mid-fetch aborts the access; the first request after release is at RESET_PC.

Structure
REQ-029 The shared cpu constants file SHALL hold the state encodings, the address width (8), the instruction width (16) and the RESET_PC default.
REQ-030 One sub-module, pc_adder (8-bit address plus 1 or plus 2, modulo 256), SHALL provide the mem_addr and fetch_pc increments.

Verification
REQ-031 Scenario: reset release, memory bytes [00]=12, [01]=34, zero-wait ack, instr_ready=1 -> instr=16'h1234, pc=00, instr_valid high on cycle 3 after release (S_IDLE, S_HI, S_LO), next request at addr 02.
REQ-032 Scenario: mem_ack delayed 3 cycles in S_HI -> mem_addr held at 00 with mem_req high for 4 cycles; instr correct.
REQ-033 Scenario: instr_ready=0 for 5 cycles in S_HOLD -> instr, pc and instr_valid stable; mem_req=0 throughout.
REQ-034 Scenario: pc_load with next_pc=8'h40 in the same cycle as mem_ack in S_LO -> word dropped; next request at 40; first valid pc=40.
REQ-035 Scenario: pc_load with next_pc=8'hFF, then [FF]=AB and [00]=CD -> instr=16'hABCD, pc=FF, next mem_addr=01.
REQ-036 Scenario: rst pulse asserted while in S_LO -> instr_valid=0 and mem_req=0 immediately; refetch starts at RESET_PC.
